color_correction_matrix: RTL
============================

// Module: color_correction_matrix
// PURPOSE
//  3x3 colour-correction matrix (CCM) stage directly downstream of the white-balance corrector.
//  Takes white-balanced RGB AXI4-Stream video and computes out = M * in per pixel.
//  Clips each result to the pixel range and forwards it to the gamma/output stage.
//  Matrix sets are double-buffered; a new set takes effect only on a start-of-frame beat (tuser).
// PARAMETERS
//  PX_WIDTH        10  bits per colour component
//  COEF_INT_WIDTH  4   signed integer bits of each coefficient, sign bit included
//  FRACT_WIDTH     10  fractional bits of each coefficient
//  (derived) COEF_WIDTH = COEF_INT_WIDTH+FRACT_WIDTH
//  (derived) TDATA_WIDTH = 3*PX_WIDTH rounded up to a whole byte
// PORTS
//  clk_i        in   1              clock
//  rst_i        in   1              reset, asynchronous, active-high
//  video_i      axi4_stream_if.slave   TDATA_WIDTH  input RGB video
//  video_o      axi4_stream_if.master  TDATA_WIDTH  output RGB video
//  ccm_coef_i   in   9*COEF_WIDTH   coefficients m00..m22 row-major; m00 at the LSBs
//  ccm_upd_i    in   1              one-cycle strobe: capture ccm_coef_i into the shadow set
//  bypass_i     in   1              1 = pass tdata unmodified
//  ccm_pend_o   out  1              shadow set captured but not yet applied
// BEHAVIOUR
//  - Component packing, input and output:
//    - R = tdata[3PX-1 -: PX], B = tdata[2PX-1 -: PX], G = tdata[PX-1:0].
//    - Output padding bits above 3PX are 0.
//  - Matrix rows and columns are ordered (R, G, B):
//    - R' = m00*R + m01*G + m02*B; G' and B' use rows 1 and 2.
//  - Pipeline: 3 register stages S1 (multiply), S2 (sum + round), S3 (clip), which drives video_o.
//    - Stage k accepts a beat when its downstream stage is ready or stage k is empty.
//    - video_i.tready = S1 ready.
//    - Latency is 3 cycles from accept to video_o.tvalid while video_o.tready = 1.
//    - Throughput is 1 beat per cycle; there are no bubbles under continuous tready.
//    - With tready low, every stage holds its contents; no beat is lost or duplicated.
//  - Sideband fields tlast, tuser, tstrb, tkeep, tid and tdest travel with their beat unchanged.
//  - Arithmetic:
//    - Each pixel is zero-extended to PX+1 bits signed and multiplied by a signed coefficient.
//    - Each product is PX+1+COEF_WIDTH bits; the sum is sign-extended by 2 bits.
//    - The sum is rounded by adding 2^(FRACT_WIDTH-1), then arithmetic-shifted right by FRACT_WIDTH.
//    - Clip: result < 0 gives 0; result > 2^PX-1 gives 2^PX-1; otherwise the low PX bits.
//  - Bypass:
//    - bypass_i is sampled with each beat at S1 acceptance and carried along the pipe.
//    - A bypassed beat leaves with its input tdata, same 3-cycle latency.
//  - Coefficient sets:
//    - active: drives S1. Reset value is identity (diagonal 1<<FRACT_WIDTH, all others 0).
//    - shadow: written only by ccm_upd_i.
//  - Pending flag:
//    - ccm_pend_o resets to 0.
//    - ccm_upd_i sets it to 1; a later ccm_upd_i before apply overwrites the shadow (last one wins).
//  - Apply:
//    - Occurs on a video_i handshake with tuser=1 while ccm_pend_o=1.
//    - active <= shadow and ccm_pend_o <= 0.
//    - That SOF beat itself is computed with the shadow (new) set, via a bypass mux at S1.
//  - ccm_upd_i in the same cycle as an applying SOF handshake:
//    - The old shadow is applied.
//    - The new value is captured into the shadow.
//    - ccm_pend_o stays 1.
//  - ccm_upd_i in the same cycle as a SOF handshake with no pending set:
//    - The new value is captured and pending; it is applied at the next SOF.
//  - Reset (asynchronous, any time, including mid-frame):
//    - All stage valids, video_o fields and ccm_pend_o go to 0.
//    - active returns to identity; shadow contents are don't-care.
//    - In-flight beats are discarded.
// TESTING
//  1. Identity after reset, 1920-pixel line of ramp data -> output equals input, 3-cycle latency, tlast on pixel 1919.
//  2. Swap matrix (m01=m10=m22=1.0), R=100 G=200 B=300 -> R'=200 G'=100 B'=300.
//  3. Clipping: m00=2.0 with R=1000 -> R'=1023; m00=-1.0 with R=5 -> R'=0; m00=0.5 with R=3 -> R'=2 (round half up).
//  4. Update timing: ccm_upd_i mid-frame -> ccm_pend_o=1; remaining pixels use the old set; first pixel of the next frame (tuser=1) uses the new set; ccm_pend_o clears on that beat.
//  5. Random video_o.tready (50%) with random input tvalid over 2 frames -> output beat sequence matches the reference model exactly; no drops or duplicates.
//  6. rst_i asserted mid-line -> video_o.tvalid=0 immediately; after release the next frame uses the identity matrix.

Source files
------------

// File: rtl/color_correction_matrix.sv
// ----------------------------------------------------------------------------
// color_correction_matrix
//
// Purpose:
//   3x3 colour-correction matrix stage placed after the white-balance
//   corrector. For every RGB beat it computes out = M * in, rounds to the
//   nearest integer (half up), clips to the pixel range and forwards the
//   result to the gamma/output stage. Coefficient sets are double-buffered:
//   a new set is captured into a shadow register and only becomes active on
//   a start-of-frame beat (tuser), so a frame never mixes two matrices.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   video_i_*             AXI4-Stream slave (tdata/tvalid/tready/tlast/tuser/
//                         tstrb/tkeep/tid/tdest), R|B|G packed, G at the LSBs
//   video_o_*             AXI4-Stream master, same fields and packing
//   ccm_coef_i            9 signed fixed-point coefficients m00..m22,
//                         row-major, m00 at the LSBs
//   ccm_upd_i             one-cycle strobe: capture ccm_coef_i into shadow
//   bypass_i              1 = beat leaves with its input tdata unmodified
//   ccm_pend_o            shadow set captured but not yet applied
//
// Pipeline: S1 multiply -> S2 sum + round -> S3 clip (drives video_o).
// ----------------------------------------------------------------------------
module color_correction_matrix #(
    parameter int PX_WIDTH       = 10,
    parameter int COEF_INT_WIDTH = 4,
    parameter int FRACT_WIDTH    = 10,
    parameter int ID_WIDTH       = 4,
    parameter int DEST_WIDTH     = 4,
    localparam int COEF_WIDTH    = COEF_INT_WIDTH + FRACT_WIDTH,
    localparam int TDATA_WIDTH   = ((3 * PX_WIDTH + 7) / 8) * 8,
    localparam int KEEP_WIDTH    = TDATA_WIDTH / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [TDATA_WIDTH-1:0]  video_i_tdata,
    input  logic                    video_i_tvalid,
    output logic                    video_i_tready,
    input  logic                    video_i_tlast,
    input  logic                    video_i_tuser,
    input  logic [KEEP_WIDTH-1:0]   video_i_tstrb,
    input  logic [KEEP_WIDTH-1:0]   video_i_tkeep,
    input  logic [ID_WIDTH-1:0]     video_i_tid,
    input  logic [DEST_WIDTH-1:0]   video_i_tdest,

    output logic [TDATA_WIDTH-1:0]  video_o_tdata,
    output logic                    video_o_tvalid,
    input  logic                    video_o_tready,
    output logic                    video_o_tlast,
    output logic                    video_o_tuser,
    output logic [KEEP_WIDTH-1:0]   video_o_tstrb,
    output logic [KEEP_WIDTH-1:0]   video_o_tkeep,
    output logic [ID_WIDTH-1:0]     video_o_tid,
    output logic [DEST_WIDTH-1:0]   video_o_tdest,

    input  logic [9*COEF_WIDTH-1:0] ccm_coef_i,
    input  logic                    ccm_upd_i,
    input  logic                    bypass_i,
    output logic                    ccm_pend_o
);

    localparam int PROD_W = PX_WIDTH + 1 + COEF_WIDTH;
    localparam int SUM_W  = PROD_W + 2;
    localparam int RES_W  = SUM_W - FRACT_WIDTH;
    localparam int SB_W   = 2 + 2 * KEEP_WIDTH + ID_WIDTH + DEST_WIDTH;

    // Identity matrix: 1.0 on the diagonal (elements 0, 4, 8), 0 elsewhere.
    function automatic logic [9*COEF_WIDTH-1:0] identity_set();
        logic [9*COEF_WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < 3; k++) begin
            v[(4 * k) * COEF_WIDTH +: COEF_WIDTH] = COEF_WIDTH'(1 << FRACT_WIDTH);
        end
        return v;
    endfunction

    localparam logic [9*COEF_WIDTH-1:0] IDENTITY = identity_set();

    // ------------------------------------------------------------------
    // Stage registers and handshake
    // ------------------------------------------------------------------
    logic                     s1_valid, s2_valid, s3_valid;
    logic                     s1_ready, s2_ready, s3_ready;
    logic                     s1_bypass, s2_bypass;
    logic [TDATA_WIDTH-1:0]   s1_data, s2_data, s3_data;
    logic [SB_W-1:0]          s1_sb, s2_sb, s3_sb;
    logic signed [PROD_W-1:0] s1_prod [9];
    logic signed [RES_W-1:0]  s2_res  [3];

    // A stage can take a new beat when it is empty or its content moves on.
    assign s3_ready = !s3_valid || video_o_tready;
    assign s2_ready = !s2_valid || s3_ready;
    assign s1_ready = !s1_valid || s2_ready;

    assign video_i_tready = s1_ready;

    // ------------------------------------------------------------------
    // Coefficient double buffer
    // ------------------------------------------------------------------
    logic [9*COEF_WIDTH-1:0] active_coef, shadow_coef, use_coef;
    logic                    pend;
    logic                    in_hs, apply;

    assign in_hs    = video_i_tvalid && s1_ready;
    assign apply    = in_hs && video_i_tuser && pend;
    // The applying SOF beat already uses the new set, so S1 sees the
    // shadow directly instead of waiting for the active register update.
    assign use_coef = apply ? shadow_coef : active_coef;
    assign ccm_pend_o = pend;

    // A strobe coinciding with an apply still wins the pending flag: the old
    // shadow moves to active while the new value waits for the next SOF.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_coef <= IDENTITY;
            shadow_coef <= '0;
            pend        <= 1'b0;
        end else begin
            if (apply) begin
                active_coef <= shadow_coef;
            end
            if (ccm_upd_i) begin
                shadow_coef <= ccm_coef_i;
                pend        <= 1'b1;
            end else if (apply) begin
                pend        <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: per-element products
    // ------------------------------------------------------------------
    logic [PX_WIDTH-1:0]      in_px [3];
    logic signed [PROD_W-1:0] prod  [9];

    // Column order is (R, G, B) although tdata packs R|B|G.
    assign in_px[0] = video_i_tdata[3*PX_WIDTH-1 -: PX_WIDTH];
    assign in_px[1] = video_i_tdata[PX_WIDTH-1:0];
    assign in_px[2] = video_i_tdata[2*PX_WIDTH-1 -: PX_WIDTH];

    // Pixel zero-extended, coefficient sign-extended, both to the full
    // product width so the multiply is exact in PROD_W bits.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                prod[r*3+c] =
                    $signed({{(PROD_W-PX_WIDTH){1'b0}}, in_px[c]}) *
                    $signed({{(PROD_W-COEF_WIDTH){use_coef[(r*3+c)*COEF_WIDTH+COEF_WIDTH-1]}},
                             use_coef[(r*3+c)*COEF_WIDTH +: COEF_WIDTH]});
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_data   <= '0;
            s1_sb     <= '0;
            for (int k = 0; k < 9; k++) begin
                s1_prod[k] <= '0;
            end
        end else if (s1_ready) begin
            s1_valid <= video_i_tvalid;
            if (video_i_tvalid) begin
                s1_bypass <= bypass_i;
                s1_data   <= video_i_tdata;
                s1_sb     <= {video_i_tlast, video_i_tuser, video_i_tstrb,
                              video_i_tkeep, video_i_tid, video_i_tdest};
                for (int k = 0; k < 9; k++) begin
                    s1_prod[k] <= prod[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: row sums, round half up, drop fraction bits
    // ------------------------------------------------------------------
    logic signed [SUM_W-1:0] sum [3];
    logic signed [RES_W-1:0] rnd [3];

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            sum[r] = $signed({{2{s1_prod[r*3][PROD_W-1]}},   s1_prod[r*3]})
                   + $signed({{2{s1_prod[r*3+1][PROD_W-1]}}, s1_prod[r*3+1]})
                   + $signed({{2{s1_prod[r*3+2][PROD_W-1]}}, s1_prod[r*3+2]})
                   + $signed(SUM_W'(1 << (FRACT_WIDTH - 1)));
            // Taking the upper bits is the arithmetic shift by FRACT_WIDTH.
            rnd[r] = sum[r][SUM_W-1:FRACT_WIDTH];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid  <= 1'b0;
            s2_bypass <= 1'b0;
            s2_data   <= '0;
            s2_sb     <= '0;
            for (int r = 0; r < 3; r++) begin
                s2_res[r] <= '0;
            end
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_bypass <= s1_bypass;
                s2_data   <= s1_data;
                s2_sb     <= s1_sb;
                for (int r = 0; r < 3; r++) begin
                    s2_res[r] <= rnd[r];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: clip to [0, 2^PX-1] and repack R|B|G with zero padding
    // ------------------------------------------------------------------
    logic [PX_WIDTH-1:0]    clip [3];
    logic [TDATA_WIDTH-1:0] calc_data;

    always_comb begin
        calc_data = '0;
        for (int r = 0; r < 3; r++) begin
            if (s2_res[r][RES_W-1]) begin
                clip[r] = '0;
            end else if (|s2_res[r][RES_W-2:PX_WIDTH]) begin
                clip[r] = '1;
            end else begin
                clip[r] = s2_res[r][PX_WIDTH-1:0];
            end
        end
        calc_data[3*PX_WIDTH-1 -: PX_WIDTH] = clip[0];
        calc_data[2*PX_WIDTH-1 -: PX_WIDTH] = clip[2];
        calc_data[PX_WIDTH-1:0]             = clip[1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_sb    <= '0;
        end else if (s3_ready) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_data <= s2_bypass ? s2_data : calc_data;
                s3_sb   <= s2_sb;
            end
        end
    end

    assign video_o_tvalid = s3_valid;
    assign video_o_tdata  = s3_data;
    assign {video_o_tlast, video_o_tuser, video_o_tstrb,
            video_o_tkeep, video_o_tid, video_o_tdest} = s3_sb;

endmodule
